// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle Q-format constants, twiddle/quadrant types and
// the constant function that builds the quarter-wave cosine table at elaboration.
package fft_pkg;

   localparam int  TWID_WIDTH_DEF = 16;
   localparam real PI             = 3.14159265358979323846;

   typedef logic signed [TWID_WIDTH_DEF-1:0] tw_t;
   typedef logic [1:0]                       quad_t;

   // Full-scale magnitude of a signed Q1.(w-1) value; kept symmetric so negation never overflows.
   function automatic int q_scale(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // r stays within the first quadrant, so the scaled cosine is never negative.
   function automatic int cos_q(input int r, input int n, input int w);
      real a;
      a = $cos(2.0 * PI * real'(r) / real'(n)) * real'(q_scale(w));
      return $rtoi(a + 0.5);
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Registered quarter-wave cosine ROM, two read ports, 1-cycle latency.
// Each port can negate its entry as it is registered, which keeps the twiddle output fully registered.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int N_POINTS   = 64,
   parameter int TWID_WIDTH = 16,
   parameter int AW         = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [AW-1:0]         addr_a,
   input  logic                  neg_a,
   input  logic [AW-1:0]         addr_b,
   input  logic                  neg_b,
   output logic [TWID_WIDTH-1:0] rd_a,
   output logic [TWID_WIDTH-1:0] rd_b
);

   localparam int DEPTH = N_POINTS / 4 + 1;

   logic [TWID_WIDTH-1:0] rom [0:DEPTH-1];

   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign rom[g] = TWID_WIDTH'(cos_q(g, N_POINTS, TWID_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_a <= '0;
         rd_b <= '0;
      end else if (en) begin
         rd_a <= neg_a ? -rom[addr_a] : rom[addr_a];
         rd_b <= neg_b ? -rom[addr_b] : rom[addr_b];
      end
   end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streaming W_N^k generator for one radix-4 DIT stage, 2-cycle aligned with the data.
// Optional macro TWID_GEN_INVERSE_EN adds per-sample input inv that conjugates the twiddle (IFFT).
module twiddle_gen
   import fft_pkg::*;
#(
   parameter int N_POINTS   = 64,
   parameter int LOG2N      = 6,
   parameter int STAGE      = 0,
   parameter int DATA_WIDTH = 21,
   parameter int TWID_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic                  in_sync,
`ifdef TWID_GEN_INVERSE_EN
   input  logic                  inv,
`endif
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_i,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic [DATA_WIDTH-1:0] out_i,
   output logic [TWID_WIDTH-1:0] tw_r,
   output logic [TWID_WIDTH-1:0] tw_i,
   output logic                  frame_err
);

   // state | meaning
   // IDLE  | waiting for a sync sample; unsynced samples are dropped
   // RUN   | counting samples modulo N_POINTS, across frames
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam int LOG2L = 2 * (STAGE + 1);
   localparam int L     = 1 << LOG2L;
   localparam int AW    = LOG2N - 1;
   localparam int KW    = LOG2N + 2;
   localparam logic [AW-1:0]    QUARTER = AW'(N_POINTS / 4);
   localparam logic [LOG2N-1:0] N_LAST  = LOG2N'(N_POINTS - 1);

   logic [0:0]       state;
   logic [LOG2N-1:0] n;
   logic             inv_s;
   logic             accept;
   logic             sync_err;
   logic [LOG2N-1:0] n_cur;
   logic [KW-1:0]    p, leg, j, prod;
   logic [LOG2N-1:0] k;
   quad_t            q;
   logic [AW-1:0]    r;

`ifdef TWID_GEN_INVERSE_EN
   assign inv_s = inv;
`else
   assign inv_s = 1'b0;
`endif

   always_comb begin
      accept   = in_valid & ((state == RUN) | in_sync);
      sync_err = in_valid & in_sync & (state == RUN) & (n != '0);
      n_cur    = in_sync ? '0 : n;
      p        = KW'(n_cur) & KW'(L - 1);
      leg      = p >> (LOG2L - 2);
      j        = p & KW'(L / 4 - 1);
      prod     = leg * j;
      k        = LOG2N'(prod << (LOG2N - LOG2L));
      q        = k[LOG2N-1 -: 2];
      r        = {1'b0, k[LOG2N-3:0]};
   end

   logic                  v1, last1, err1, neg_a1, neg_b1;
   logic [DATA_WIDTH-1:0] r1, i1;
   logic [AW-1:0]         addr_a1, addr_b1;

   // Odd quadrants swap which ROM port feeds the real part; signs follow cos - j*sin per quadrant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         n       <= '0;
         v1      <= 1'b0;
         last1   <= 1'b0;
         err1    <= 1'b0;
         r1      <= '0;
         i1      <= '0;
         addr_a1 <= '0;
         addr_b1 <= '0;
         neg_a1  <= 1'b0;
         neg_b1  <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) begin
            state   <= RUN;
            n       <= n_cur + 1'b1;
            last1   <= (n_cur == N_LAST);
            err1    <= sync_err;
            r1      <= in_r;
            i1      <= in_i;
            addr_a1 <= q[0] ? QUARTER - r : r;
            addr_b1 <= q[0] ? r : QUARTER - r;
            neg_a1  <= q[0] ^ q[1];
            neg_b1  <= ~q[1] ^ inv_s;
         end
      end
   end

   logic                  v2, last2, err2;
   logic [DATA_WIDTH-1:0] r2, i2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         last2 <= 1'b0;
         err2  <= 1'b0;
         r2    <= '0;
         i2    <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            last2 <= last1;
            err2  <= err1;
            r2    <= r1;
            i2    <= i1;
         end
      end
   end

   twiddle_rom #(
      .N_POINTS   (N_POINTS),
      .TWID_WIDTH (TWID_WIDTH),
      .AW         (AW)
   ) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (v1),
      .addr_a (addr_a1),
      .neg_a  (neg_a1),
      .addr_b (addr_b1),
      .neg_b  (neg_b1),
      .rd_a   (tw_r),
      .rd_b   (tw_i)
   );

   assign out_valid = v2;
   assign out_last  = v2 & last2;
   assign frame_err = v2 & err2;
   assign out_r     = r2;
   assign out_i     = i2;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: STAGE=0 and STAGE=1 instances share one random stream and are
// compared every cycle against a trigonometric reference model of the sample index and twiddle.
module tb_twiddle_gen;

   localparam int N  = 64;
   localparam int DW = 21;
   localparam int TW = 16;

   typedef struct {
      bit v;
      bit last;
      bit err;
      int dr;
      int di;
      int twr0;
      int twi0;
      int twr1;
      int twi1;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_sync;
   logic [DW-1:0] in_r;
   logic [DW-1:0] in_i;
   logic          o_valid [2];
   logic          o_last  [2];
   logic          o_err   [2];
   logic [DW-1:0] o_r     [2];
   logic [DW-1:0] o_i     [2];
   logic [TW-1:0] o_twr   [2];
   logic [TW-1:0] o_twi   [2];

   int n_checks = 0;
   int n_fail   = 0;

   bit   m_run;
   int   m_n;
   exp_t pipe0, pipe1, held;

   twiddle_gen #(.N_POINTS(N), .LOG2N(6), .STAGE(0), .DATA_WIDTH(DW), .TWID_WIDTH(TW)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
`ifdef TWID_GEN_INVERSE_EN
      .inv       (1'b0),
`endif
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (o_valid[0]),
      .out_last  (o_last[0]),
      .out_r     (o_r[0]),
      .out_i     (o_i[0]),
      .tw_r      (o_twr[0]),
      .tw_i      (o_twi[0]),
      .frame_err (o_err[0])
   );

   twiddle_gen #(.N_POINTS(N), .LOG2N(6), .STAGE(1), .DATA_WIDTH(DW), .TWID_WIDTH(TW)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
`ifdef TWID_GEN_INVERSE_EN
      .inv       (1'b0),
`endif
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (o_valid[1]),
      .out_last  (o_last[1]),
      .out_r     (o_r[1]),
      .out_i     (o_i[1]),
      .tw_r      (o_twr[1]),
      .tw_i      (o_twi[1]),
      .frame_err (o_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int round_q(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(0.5 - x);
   endfunction

   function automatic int k_of(input int idx, input int stage);
      int span, p, leg, j;
      span = 4 ** (stage + 1);
      p    = idx % span;
      leg  = p / (span / 4);
      j    = p % (span / 4);
      return (leg * j * (N / span)) % N;
   endfunction

   task automatic tw_of(input int k, output int tr, output int ti);
      real ang, sc;
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      sc  = real'((1 << (TW - 1)) - 1);
      tr  = round_q($cos(ang) * sc);
      ti  = round_q(-$sin(ang) * sc);
   endtask

   // One clock cycle: check what the DUTs show now, then present the next input.
   task automatic step(input bit rst, input bit v, input bit s);
      exp_t          e;
      logic [DW-1:0] dr, di;
      int            idx;
      @(negedge clk);
      if (pipe1.v) held = pipe1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("s%0d_out_valid", d), 32'(o_valid[d]), 32'(pipe1.v));
         chk($sformatf("s%0d_out_last", d), 32'(o_last[d]), 32'(pipe1.v & pipe1.last));
         chk($sformatf("s%0d_frame_err", d), 32'(o_err[d]), 32'(pipe1.v & pipe1.err));
         chk($sformatf("s%0d_out_r", d), 32'(o_r[d]), held.dr);
         chk($sformatf("s%0d_out_i", d), 32'(o_i[d]), held.di);
         chk($sformatf("s%0d_tw_r", d), 32'($signed(o_twr[d])), (d == 0) ? held.twr0 : held.twr1);
         chk($sformatf("s%0d_tw_i", d), 32'($signed(o_twi[d])), (d == 0) ? held.twi0 : held.twi1);
      end
      dr       = DW'($urandom);
      di       = DW'($urandom);
      rst_n    = ~rst;
      in_valid = v;
      in_sync  = s;
      in_r     = dr;
      in_i     = di;
      e = '{default: 0};
      if (rst) begin
         m_run = 1'b0;
         m_n   = 0;
         pipe0 = '{default: 0};
         pipe1 = '{default: 0};
         held  = '{default: 0};
      end else begin
         if (v && (m_run || s)) begin
            idx    = s ? 0 : m_n;
            e.err  = m_run && s && (m_n != 0);
            m_run  = 1'b1;
            m_n    = (idx + 1) % N;
            e.v    = 1'b1;
            e.last = (idx == N - 1);
            e.dr   = int'(dr);
            e.di   = int'(di);
            tw_of(k_of(idx, 0), e.twr0, e.twi0);
            tw_of(k_of(idx, 1), e.twr1, e.twi1);
         end
         pipe1 = pipe0;
         pipe0 = e;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_r     = '0;
      in_i     = '0;
      m_run    = 1'b0;
      m_n      = 0;
      pipe0    = '{default: 0};
      pipe1    = '{default: 0};
      held     = '{default: 0};

      repeat (2) step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      repeat (5) step(0, 1, 0);

      // gap-free frame
      step(0, 1, 1);
      repeat (N - 1) step(0, 1, 0);

      // gapped frame, 1-of-3 duty, legal sync at n=0
      for (int i = 0; i < N; i++) begin
         step(0, 1, i == 0);
         repeat (2) step(0, 0, 0);
      end

      // early sync at n=20
      repeat (20) step(0, 1, 0);
      step(0, 1, 1);
      repeat (15) step(0, 1, 0);

      // mid-frame reset, then unsynced samples are dropped until a new sync
      step(1, 1, 0);
      repeat (4) step(0, 1, 0);
      step(0, 1, 1);
      repeat (40) step(0, 1, 0);

      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);

      repeat (3) step(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
